div10by5_seq: RTL



---
 rtl/div_pkg.sv | 19 +
 rtl/div_step.sv | 24 ++
 rtl/div10by5_seq.sv | 124 ++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared arithmetic-datapath definitions for the restoring divider and its
// companion 5x5 multiplier bench.
package div_pkg;

  localparam int DW = 10;
  localparam int VW = 5;
  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Quotient reported for a zero divisor: saturate to all ones.
  localparam logic [DW-1:0] DBZ_QUOT  = '1;
  localparam logic [CW-1:0] ITER_LOAD = CW'(DW);

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// conditionally subtract the divisor and emit one quotient bit.
module div_step
  import div_pkg::*;
(
  input  logic [VW:0]   partial_i,
  input  logic          bit_i,
  input  logic [VW-1:0] divisor_i,
  output logic [VW:0]   partial_o,
  output logic          qbit_o
);

  logic [VW+1:0] p_wide;

  // The partial remainder always stays below the divisor, so its top bit is
  // zero; comparing the full shifted value is therefore equivalent to
  // comparing {partial[VW-1:0], bit} and never overflows.
  always_comb begin
    p_wide    = {partial_i, bit_i};
    qbit_o    = (p_wide >= {2'b00, divisor_i});
    partial_o = qbit_o ? (p_wide[VW:0] - {1'b0, divisor_i}) : p_wide[VW:0];
  end

endmodule

// File: rtl/div10by5_seq.sv
// Sequential unsigned restoring divider, DW-bit dividend by VW-bit divisor,
// one quotient bit per clock.
module div10by5_seq
  import div_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          dbz,
  output state_e        state_dbg
);

  // Handshake: start is taken on any edge where the FSM is in IDLE or DONE
  // (busy=0); operands are sampled on that same edge. While busy=1, start and
  // operands are ignored. done pulses for one cycle with quotient/remainder/
  // dbz valid, and those results hold until the next accepted start.

  state_e        state_q,     state_d;
  logic [DW-1:0] work_q,      work_d;
  logic [VW-1:0] divisor_q,   divisor_d;
  logic [VW:0]   partial_q,   partial_d;
  logic [CW-1:0] count_q,     count_d;
  logic [DW-1:0] quot_q,      quot_d;
  logic [VW-1:0] rem_q,       rem_d;
  logic          dbz_q,       dbz_d;

  logic [VW:0]   step_partial;
  logic          step_qbit;

  // The working register doubles as dividend shifter and quotient collector:
  // the MSB feeds the step and the new quotient bit enters at the LSB.
  div_step u_step (
    .partial_i (partial_q),
    .bit_i     (work_q[DW-1]),
    .divisor_i (divisor_q),
    .partial_o (step_partial),
    .qbit_o    (step_qbit)
  );

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    partial_d = partial_q;
    count_d   = count_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dbz_d     = dbz_q;

    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) begin
          state_d = IDLE;
        end
        if (start) begin
          if (divisor != '0) begin
            state_d   = RUN;
            work_d    = dividend;
            divisor_d = divisor;
            partial_d = '0;
            count_d   = ITER_LOAD;
          end else begin
            state_d = DONE;
            quot_d  = DBZ_QUOT;
            rem_d   = dividend[VW-1:0];
            dbz_d   = 1'b1;
          end
        end
      end

      RUN: begin
        work_d    = {work_q[DW-2:0], step_qbit};
        partial_d = step_partial;
        count_d   = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d = DONE;
          quot_d  = work_d;
          rem_d   = step_partial[VW-1:0];
          dbz_d   = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      work_q    <= '0;
      divisor_q <= '0;
      partial_q <= '0;
      count_q   <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      partial_q <= partial_d;
      count_q   <= count_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign dbz       = dbz_q;
  assign state_dbg = state_q;

endmodule
